// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gpio_debounce
// Description : Input conditioning for GPIO pads. Each bit passes through a
//               two-flop synchronizer and then an optional per-bit stability
//               filter. The conditioned levels are then used for edge and level
//               detection and for the input data register.
// Ports       : clk_i         core clock, rising edge
//               rst_ni        asynchronous active-low reset
//               gpio_pad_i    raw pad levels, asynchronous to clk_i
//               db_enable_i   per-bit debounce enable (0 = synchronize only)
//               db_limit_i    extra stable cycles required before acceptance
//               gpio_input_o  conditioned, registered levels
//               gpio_change_o registered one-cycle pulse per changed bit
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] gpio_pad_i,
    input  logic [WIDTH-1:0] db_enable_i,
    input  logic [CNT_W-1:0] db_limit_i,
    output logic [WIDTH-1:0] gpio_input_o,
    output logic [WIDTH-1:0] gpio_change_o
);

    // Synchronizer stages. Nothing sits between stage 1 and stage 2 so the
    // first flop gets a full cycle to resolve metastability.
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Filter state
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] chg_q;
    logic [WIDTH-1:0] chg_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            out_d[i] = out_q[i];
            cnt_d[i] = '0;
            chg_d[i] = 1'b0;
            if (!db_enable_i[i]) begin
                // Bypass: follow the synchronized level directly.
                out_d[i] = sync2_q[i];
                chg_d[i] = (sync2_q[i] != out_q[i]);
            end else if (sync2_q[i] != out_q[i]) begin
                // The >= compare lets a lowered limit take effect immediately
                // and keeps the counter from ever passing the limit.
                if (cnt_q[i] >= db_limit_i) begin
                    out_d[i] = sync2_q[i];
                    chg_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            // Level back at the accepted value: the counter clears, which is
            // what discards short glitches.
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            out_q   <= '0;
            chg_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= gpio_pad_i;
            sync2_q <= sync1_q;
            out_q   <= out_d;
            chg_q   <= chg_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_input_o  = out_q;
    assign gpio_change_o = chg_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_debounce
// Description : Self-checking bench for gpio_debounce. A cycle-level reference
//               model queues expected outputs on every rising edge; they are
//               popped and compared on the following falling edge. Directed
//               latency checks cover the key timing points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_debounce;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  pad;
    logic [W-1:0]  en;
    logic [CW-1:0] lim;
    logic [W-1:0]  dut_in;
    logic [W-1:0]  dut_chg;

    int n_checks = 0;
    int n_errors = 0;

    gpio_debounce #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .gpio_pad_i   (pad),
        .db_enable_i  (en),
        .db_limit_i   (lim),
        .gpio_input_o (dut_in),
        .gpio_change_o(dut_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [W-1:0]  m_s1, m_s2, m_out, m_chg;
    int            m_cnt [W];
    logic [2*W-1:0] sb_q [$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_chg = '0;
            for (int i = 0; i < W; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < W; i++) begin
                m_chg[i] = 1'b0;
                if (!en[i]) begin
                    m_chg[i] = (m_s2[i] != m_out[i]);
                    m_out[i] = m_s2[i];
                    m_cnt[i] = 0;
                end else if (m_s2[i] == m_out[i]) begin
                    m_cnt[i] = 0;
                end else if (m_cnt[i] >= int'(lim)) begin
                    m_out[i] = m_s2[i];
                    m_cnt[i] = 0;
                    m_chg[i] = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            m_s2 = m_s1;
            m_s1 = pad;
        end
        sb_q.push_back({m_out, m_chg});
    end

    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_input", dut_in, e[2*W-1:W]);
            check("sb_change", dut_chg, e[W-1:0]);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic edge_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] bit_of(input logic [W-1:0] v, input int b);
        logic [W-1:0] r;
        r = '0;
        r[0] = v[b];
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        pad   = 32'hFFFF_FFFF;
        en    = '0;
        lim   = '0;

        // Reset with all pads high
        repeat (3) @(negedge clk);
        #1;
        check("rst_input", dut_in, '0);
        check("rst_change", dut_chg, '0);
        @(negedge clk);
        rst_n = 1'b1;
        edge_n(2);
        check("post_rst_e2_input", dut_in, '0);
        edge_n(1);
        check("post_rst_e3_input", dut_in, 32'hFFFF_FFFF);
        check("post_rst_e3_change", dut_chg, 32'hFFFF_FFFF);
        edge_n(1);
        check("post_rst_e4_change", dut_chg, '0);

        @(negedge clk);
        pad = '0;
        edge_n(5);

        // Bypass latency on bit 5
        @(negedge clk);
        pad[5] = 1'b1;
        edge_n(2);
        check("byp_e2_in5", bit_of(dut_in, 5), 32'd0);
        edge_n(1);
        check("byp_e3_in5", bit_of(dut_in, 5), 32'd1);
        check("byp_e3_chg5", bit_of(dut_chg, 5), 32'd1);
        edge_n(1);
        check("byp_e4_chg5", bit_of(dut_chg, 5), 32'd0);

        // Debounce accept, L = 4
        @(negedge clk);
        en[0] = 1'b1; lim = 16'd4; pad[0] = 1'b1;
        edge_n(6);
        check("db_rise_e6_in0", bit_of(dut_in, 0), 32'd0);
        edge_n(1);
        check("db_rise_e7_in0", bit_of(dut_in, 0), 32'd1);
        check("db_rise_e7_chg0", bit_of(dut_chg, 0), 32'd1);
        edge_n(1);
        check("db_rise_e8_chg0", bit_of(dut_chg, 0), 32'd0);
        @(negedge clk);
        pad[0] = 1'b0;
        edge_n(6);
        check("db_fall_e6_in0", bit_of(dut_in, 0), 32'd1);
        edge_n(1);
        check("db_fall_e7_in0", bit_of(dut_in, 0), 32'd0);
        check("db_fall_e7_chg0", bit_of(dut_chg, 0), 32'd1);

        // Glitch of 4 cycles rejected with L = 4
        @(negedge clk);
        pad[0] = 1'b1;
        repeat (4) @(negedge clk);
        pad[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            edge_n(1);
            check("glitch_in0", bit_of(dut_in, 0), 32'd0);
            check("glitch_chg0", bit_of(dut_chg, 0), 32'd0);
        end

        // Limit lowered mid-count on bit 3
        @(negedge clk);
        en[3] = 1'b1; lim = 16'd10; pad[3] = 1'b1;
        edge_n(8);
        check("lim_e8_in3", bit_of(dut_in, 3), 32'd0);
        @(negedge clk);
        lim = 16'd2;
        edge_n(1);
        check("lim_e9_in3", bit_of(dut_in, 3), 32'd1);
        check("lim_e9_chg3", bit_of(dut_chg, 3), 32'd1);

        // Mixed: bit 1 bypassed, bit 2 debounced with L = 3
        @(negedge clk);
        en[1] = 1'b0; en[2] = 1'b1; lim = 16'd3;
        pad[1] = 1'b1; pad[2] = 1'b1;
        edge_n(3);
        check("mix_e3_in1", bit_of(dut_in, 1), 32'd1);
        check("mix_e3_chg1", bit_of(dut_chg, 1), 32'd1);
        check("mix_e3_in2", bit_of(dut_in, 2), 32'd0);
        edge_n(2);
        check("mix_e5_in2", bit_of(dut_in, 2), 32'd0);
        check("mix_e5_chg1", bit_of(dut_chg, 1), 32'd0);
        edge_n(1);
        check("mix_e6_in2", bit_of(dut_in, 2), 32'd1);
        check("mix_e6_chg2", bit_of(dut_chg, 2), 32'd1);
        edge_n(1);
        check("mix_e7_chg2", bit_of(dut_chg, 2), 32'd0);

        // Enable dropped mid-count on bit 7: bypass applies on that edge
        @(negedge clk);
        en[7] = 1'b1; lim = 16'd8; pad[7] = 1'b1;
        edge_n(4);
        check("entog_e4_in7", bit_of(dut_in, 7), 32'd0);
        @(negedge clk);
        en[7] = 1'b0;
        edge_n(1);
        check("entog_in7", bit_of(dut_in, 7), 32'd1);
        check("entog_chg7", bit_of(dut_chg, 7), 32'd1);

        // Reset asserted mid-count on bit 8, then recovery
        @(negedge clk);
        en[8] = 1'b1; lim = 16'd6; pad[8] = 1'b1;
        edge_n(5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_input", dut_in, '0);
        check("midrst_change", dut_chg, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
